// File: rtl/render_cmd_scheduler.sv
// render_cmd_scheduler: round-robin arbiter feeding a 48-bit render command
// queue that drains into the VGA display engine's instruction fetch port.
// A frame commit appends one DO_RENDER after every command already accepted.
// Malformed commands are acknowledged but dropped and counted.
// Optional build macro: RENDER_SCHED_FRAME_STATS_EN adds frame_cmd_cnt, the
// number of sprite commands enqueued in the frame closed by the last DO_RENDER.
module render_cmd_scheduler #(
    parameter int          NUM_REQ         = 3,
    parameter int          DEPTH           = 16,
    parameter int          NUM_SPRITES     = 9,
    parameter logic [7:0]  DO_RENDER_MAGIC = 8'hFF
) (
    input  logic                       clk50,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [48*NUM_REQ-1:0]      req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic                       frame_end,
    input  logic                       render_queue_pop_front,
    output logic [47:0]                render_queue_dout,
    output logic                       render_q_lw,
    output logic [$clog2(DEPTH):0]     q_level,
`ifdef RENDER_SCHED_FRAME_STATS_EN
    output logic [15:0]                frame_cmd_cnt,
`endif
    output logic [7:0]                 bad_cmd_cnt
);

    localparam int            AW        = $clog2(DEPTH);
    localparam int            PW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [AW:0]   LP_DEPTH  = (AW+1)'(DEPTH);
    localparam logic [AW:0]   LP_SPRITE_ROOM = (AW+1)'(DEPTH-1);
    localparam logic [7:0]    LP_NSPR   = 8'(NUM_SPRITES);

    logic [47:0]        r_mem [DEPTH];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [AW:0]        r_count;
    logic               r_commit_pending;
    logic [PW-1:0]      r_rr_ptr;
    logic [7:0]         r_bad_cnt;

    logic               w_commit_push;
    logic               w_arb_en;
    logic [NUM_REQ-1:0] w_gnt;
    logic [PW-1:0]      w_gnt_idx;
    logic               w_any;
    logic [PW-1:0]      w_rr_next;
    logic [47:0]        w_gnt_cmd;
    logic               w_bad;
    logic               w_cmd_push;
    logic               w_discard;
    logic               w_push;
    logic [47:0]        w_push_data;
    logic               w_pop;

    // The last slot is held back for DO_RENDER so a commit is never starved
    // by sprites; while a commit is pending nothing from the next frame may
    // be granted ahead of it.
    assign w_commit_push = r_commit_pending && (r_count < LP_DEPTH);
    assign w_arb_en      = !reset && !r_commit_pending && (r_count < LP_SPRITE_ROOM);

    // Round-robin search starting at the requester after the last grant.
    always_comb begin
        int idx;
        w_gnt     = '0;
        w_gnt_idx = '0;
        w_any     = 1'b0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(r_rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (w_arb_en && !w_any && req_valid[idx]) begin
                w_any      = 1'b1;
                w_gnt[idx] = 1'b1;
                w_gnt_idx  = PW'(idx);
            end
        end
    end

    assign w_rr_next   = (w_gnt_idx == PW'(NUM_REQ-1)) ? '0 : w_gnt_idx + 1'b1;
    assign w_gnt_cmd   = req_data[int'(w_gnt_idx)*48 +: 48];
    assign w_bad       = (w_gnt_cmd[47:40] >= LP_NSPR) || (w_gnt_cmd[47:40] == DO_RENDER_MAGIC);
    assign w_cmd_push  = w_any && !w_bad;
    assign w_discard   = w_any && w_bad;
    // Commit push and sprite push are exclusive: grants are blocked while pending.
    assign w_push      = w_commit_push || w_cmd_push;
    assign w_push_data = w_commit_push ? {DO_RENDER_MAGIC, 40'h0} : w_gnt_cmd;
    assign w_pop       = render_queue_pop_front && (r_count != '0);

    assign req_ready         = w_gnt;
    assign render_q_lw       = (r_count == '0);
    assign render_queue_dout = (r_count != '0) ? r_mem[r_rd_ptr] : 48'h0;
    assign q_level           = r_count;
    assign bad_cmd_cnt       = r_bad_cnt;

    // Queue storage; contents need no reset since count gates visibility.
    always_ff @(posedge clk50) begin
        if (w_push) r_mem[r_wr_ptr] <= w_push_data;
    end

    // Pointers, occupancy, commit sequencing, arbitration pointer, bad count.
    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            r_wr_ptr         <= '0;
            r_rd_ptr         <= '0;
            r_count          <= '0;
            r_commit_pending <= 1'b0;
            r_rr_ptr         <= '0;
            r_bad_cnt        <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // A frame_end arriving while pending merges into the same commit.
            r_commit_pending <= (r_commit_pending && !w_commit_push) || frame_end;
            if (w_any) r_rr_ptr <= w_rr_next;
            if (w_discard && (r_bad_cnt != 8'hFF)) r_bad_cnt <= r_bad_cnt + 1'b1;
        end
    end

`ifdef RENDER_SCHED_FRAME_STATS_EN
    logic [15:0] r_run_cnt;
    logic [15:0] r_frame_cmd_cnt;

    // Count sprites per frame; latch and restart when DO_RENDER is pushed.
    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            r_run_cnt       <= '0;
            r_frame_cmd_cnt <= '0;
        end else if (w_commit_push) begin
            r_frame_cmd_cnt <= r_run_cnt;
            r_run_cnt       <= '0;
        end else if (w_cmd_push && (r_run_cnt != 16'hFFFF)) begin
            r_run_cnt <= r_run_cnt + 1'b1;
        end
    end

    assign frame_cmd_cnt = r_frame_cmd_cnt;
`endif

endmodule

// File: tb/tb_render_cmd_scheduler.sv
// Directed bench for render_cmd_scheduler with a queue-order scoreboard.
module tb_render_cmd_scheduler;

    localparam int NREQ  = 3;
    localparam int DEPTH = 16;

    logic              clk50 = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req_valid;
    logic [48*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              frame_end;
    logic              pop;
    logic [47:0]       dout;
    logic              lw;
    logic [4:0]        q_level;
    logic [7:0]        bad_cmd_cnt;
`ifdef RENDER_SCHED_FRAME_STATS_EN
    logic [15:0]       frame_cmd_cnt;
`endif

    int n_checks = 0;
    int n_err    = 0;
    logic [47:0] exp_q [$];

    localparam logic [47:0] DO_RENDER = {8'hFF, 40'h0};

    always #10 clk50 = ~clk50;

    render_cmd_scheduler #(.NUM_REQ(NREQ), .DEPTH(DEPTH), .NUM_SPRITES(9),
                           .DO_RENDER_MAGIC(8'hFF)) dut (
        .clk50(clk50), .reset(reset),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .frame_end(frame_end), .render_queue_pop_front(pop),
        .render_queue_dout(dout), .render_q_lw(lw), .q_level(q_level),
`ifdef RENDER_SCHED_FRAME_STATS_EN
        .frame_cmd_cnt(frame_cmd_cnt),
`endif
        .bad_cmd_cnt(bad_cmd_cnt)
    );

    function automatic logic [47:0] cmd(input logic [7:0] magic, input int seq);
        return {magic, 16'(seq), 16'(~seq), 8'h5A};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [47:0] c);
        req_data[48*i +: 48] = c;
    endtask

    // Called just after a negedge: compare head with scoreboard, pop one cycle.
    task automatic pop_one(input string tag);
        logic [47:0] e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_err++;
            $error("FAIL %s: observed pop with empty scoreboard expected entry", tag);
        end else begin
            e = exp_q.pop_front();
            chk(tag, 64'(dout), 64'(e));
        end
        pop = 1'b1;
        @(negedge clk50);
        pop = 1'b0;
        #1;
    endtask

    initial begin
        reset = 1'b1; req_valid = '0; req_data = '0; frame_end = 1'b0; pop = 1'b0;
        repeat (3) @(negedge clk50);
        reset = 1'b0;
        #1;
        // Reset state.
        chk("rst_lw", 64'(lw), 64'd1);
        chk("rst_dout", 64'(dout), 64'd0);
        chk("rst_level", 64'(q_level), 64'd0);
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_bad", 64'(bad_cmd_cnt), 64'd0);
        // Pop on empty queue is ignored.
        pop = 1'b1;
        @(negedge clk50);
        pop = 1'b0;
        #1;
        chk("empty_pop_level", 64'(q_level), 64'd0);
        chk("empty_pop_dout", 64'(dout), 64'd0);

        // Round-robin: three requesters with magics 1,2,3.
        set_req(0, cmd(8'd1, 0)); set_req(1, cmd(8'd2, 1)); set_req(2, cmd(8'd3, 2));
        req_valid = 3'b111;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rr_grant", 64'(req_ready), 64'(3'b001 << (k % 3)));
            exp_q.push_back(cmd(8'(k % 3 + 1), k % 3));
            @(negedge clk50);
            if (k == 0) chk("rr_latency_lw", 64'(lw), 64'd0);
        end
        req_valid = '0;
        #1;
        chk("rr_level", 64'(q_level), 64'd4);
        for (int k = 0; k < 4; k++) pop_one("rr_order");
        chk("rr_drained_lw", 64'(lw), 64'd1);

        // Fill to DEPTH-1 sprites; last slot stays reserved.
        req_valid = 3'b001;
        for (int k = 0; k < DEPTH-1; k++) begin
            set_req(0, cmd(8'd5, 100 + k));
            #1;
            chk("fill_grant", 64'(req_ready), 64'd1);
            exp_q.push_back(cmd(8'd5, 100 + k));
            @(negedge clk50);
        end
        set_req(0, cmd(8'd5, 200));
        #1;
        chk("fill_level", 64'(q_level), 64'd15);
        chk("fill_no_grant", 64'(req_ready), 64'd0);
        frame_end = 1'b1;
        @(negedge clk50);
        frame_end = 1'b0;
        #1;
        chk("commit_pending_no_grant", 64'(req_ready), 64'd0);
        exp_q.push_back(DO_RENDER);
        @(negedge clk50);
        #1;
        chk("commit_full_level", 64'(q_level), 64'd16);
        chk("commit_full_ready", 64'(req_ready), 64'd0);
`ifdef RENDER_SCHED_FRAME_STATS_EN
        chk("frame_stats", 64'(frame_cmd_cnt), 64'd19);
`endif
        pop_one("fill_head");
        chk("after_pop_level", 64'(q_level), 64'd15);
        chk("after_pop_no_grant", 64'(req_ready), 64'd0);
        req_valid = '0;
        for (int k = 0; k < DEPTH-1; k++) pop_one("fill_drain");
        chk("fill_tail_is_commit", 64'(exp_q.size()), 64'd0);
        chk("fill_drained_level", 64'(q_level), 64'd0);

        // frame_end in the same cycle as a grant: the grant stays in this frame.
        set_req(1, cmd(8'd4, 300));
        req_valid = 3'b010;
        frame_end = 1'b1;
        #1;
        chk("same_cycle_grant", 64'(req_ready), 64'b010);
        exp_q.push_back(cmd(8'd4, 300));
        @(negedge clk50);
        frame_end = 1'b0;
        set_req(1, cmd(8'd6, 301));
        #1;
        chk("pending_blocks_req1", 64'(req_ready), 64'd0);
        exp_q.push_back(DO_RENDER);
        @(negedge clk50);
        #1;
        chk("req1_after_commit", 64'(req_ready), 64'b010);
        exp_q.push_back(cmd(8'd6, 301));
        @(negedge clk50);
        req_valid = '0;
        #1;
        chk("same_cycle_level", 64'(q_level), 64'd3);
        for (int k = 0; k < 3; k++) pop_one("same_cycle_order");

        // Filtering of malformed magics.
        set_req(2, cmd(8'd9, 400));
        req_valid = 3'b100;
        #1;
        chk("bad9_ack", 64'(req_ready), 64'b100);
        @(negedge clk50);
        set_req(2, cmd(8'hFF, 401));
        #1;
        chk("badFF_ack", 64'(req_ready), 64'b100);
        @(negedge clk50);
        req_valid = '0;
        #1;
        chk("bad_level", 64'(q_level), 64'd0);
        chk("bad_cnt2", 64'(bad_cmd_cnt), 64'd2);
        chk("bad_lw", 64'(lw), 64'd1);
        set_req(2, cmd(8'd200, 402));
        req_valid = 3'b100;
        repeat (298) @(negedge clk50);
        req_valid = '0;
        #1;
        chk("bad_cnt_sat", 64'(bad_cmd_cnt), 64'd255);
        chk("bad_sat_level", 64'(q_level), 64'd0);

        // Reset mid-operation: 7 entries queued plus a pending commit.
        set_req(0, cmd(8'd1, 500));
        req_valid = 3'b001;
        repeat (7) @(negedge clk50);
        req_valid = '0;
        #1;
        chk("pre_reset_level", 64'(q_level), 64'd7);
        frame_end = 1'b1;
        @(posedge clk50);
        #1;
        frame_end = 1'b0;
        reset = 1'b1;
        #2;
        chk("reset_lw", 64'(lw), 64'd1);
        chk("reset_level", 64'(q_level), 64'd0);
        @(negedge clk50);
        reset = 1'b0;
        exp_q.delete();
        repeat (3) @(negedge clk50);
        #1;
        chk("post_reset_no_commit", 64'(q_level), 64'd0);
        chk("post_reset_dout", 64'(dout), 64'd0);
        chk("post_reset_bad", 64'(bad_cmd_cnt), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/render_cmd_scheduler.md
Name: render_cmd_scheduler

Overview:
- Arbitrates sprite render commands from NUM_REQ producers (CPU Avalon shim, per-player sprite engines) into a single 48-bit render queue.
- Drains into the VGA display engine's instruction-fetch port (pop / low-water / dout).
- Sequences frames: on a frame commit it appends a DO_RENDER command after all commands already accepted, so the display swaps buffers exactly once per frame.
- Filters malformed commands before they reach the display.

Parameters:
- NUM_REQ, 3, number of requesters (1..8).
- DEPTH, 16, queue depth in commands; power of two, >= 4.
- NUM_SPRITES, 9, valid sprite magics are 0..NUM_SPRITES-1.
- DO_RENDER_MAGIC, 8'hFF, magic byte of the frame-commit command.

Ports:
- clk50  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- req_valid  in  NUM_REQ  per-requester command valid.
- req_data  in  48*NUM_REQ  commands; requester i occupies [48*i+47:48*i]; field layout {magic[47:40], x[39:24], y[23:8], flags[7:0]}.
- req_ready  out  NUM_REQ  one-hot; combinational grant in the accepting cycle.
- frame_end  in  1  one-cycle pulse: commit the current frame.
- render_queue_pop_front  in  1  display consumes the head command.
- render_queue_dout  out  48  head command, show-ahead.
- render_q_lw  out  1  high when the queue is empty (no valid head).
- q_level  out  $clog2(DEPTH)+1  occupancy.
- bad_cmd_cnt  out  8  saturating count of discarded commands.

Behaviour:
Reset values:
- Queue empty; render_q_lw=1, render_queue_dout=0, q_level=0, req_ready=0, bad_cmd_cnt=0.
- commit_pending=0, round-robin pointer=0.
- Reset asserted mid-operation flushes all contents immediately and drops any pending commit.

Queue:
- Circular buffer with wr_ptr, rd_ptr and registered count.
- dout = mem[rd_ptr] when not empty, else 0.
- A pop with render_q_lw=1 is ignored: no pointer move, no underflow.
- Simultaneous push and pop: count unchanged; both pointers advance, wrapping mod DEPTH.
- Full/room tests use the registered count. A push is not admitted on the strength of a same-cycle pop.

Commit sequencing:
- frame_end sets commit_pending. A frame_end while already pending is merged (one DO_RENDER only).
- While commit_pending=1 and count<DEPTH:
  - push {DO_RENDER_MAGIC, 40'h0};
  - clear commit_pending;
  - issue no requester grant that cycle.
- While commit_pending=1, all req_ready=0, so no later-frame command can overtake the commit.

Arbitration:
- Round-robin, at most one grant per cycle.
- Search starts at the index after the last granted requester.
- Grant only if commit_pending=0 and count<DEPTH-1. The last slot is reserved for DO_RENDER, so a commit can never be starved by a full queue of sprites.
- If frame_end arrives in the same cycle as a grant, that grant completes and belongs to the current frame. The commit is pushed on a later cycle.
- Requesters hold req_valid/req_data stable until req_ready=1.

Filtering:
- A granted command with magic>=NUM_SPRITES or magic==DO_RENDER_MAGIC is acknowledged (req_ready=1) but not enqueued.
- Each such discard increments bad_cmd_cnt, saturating at 255.

Latency:
- A command accepted in cycle N into an empty queue gives render_q_lw=0 and a valid dout in cycle N+1.
- frame_end in cycle N with room available pushes DO_RENDER in cycle N+1; it is visible at the head in N+2 if the queue is otherwise empty.

Optional Feature:
- Macro: RENDER_SCHED_FRAME_STATS_EN.
- With the macro defined:
  - add output frame_cmd_cnt[15:0], the number of sprite commands enqueued between the previous DO_RENDER push and the latest one;
  - it updates in the cycle DO_RENDER is pushed and resets to 0;
  - the running counter saturates at 16'hFFFF.
- Without the macro the port and its logic are absent.
- Queue behaviour is identical either way.

Test Plan:
- Reset, then idle: render_q_lw=1, dout=0, q_level=0. Pop with queue empty -> q_level stays 0, no X on dout.
- Requesters 0, 1 and 2 all valid with magics 1, 2, 3: grants go 0,1,2,0,... in consecutive cycles; queue order is magic 1, 2, 3, 1; each grant is one-hot.
- Fill to DEPTH-1=15 sprites with no pops: req_ready stays 0. Then frame_end -> DO_RENDER (dout[47:40]=8'hFF) pushed, q_level=16. One further pop -> still no grant while frame_end is not pending.
- frame_end in the same cycle as a grant of magic 4, requester 1 still valid -> queue tail is magic 4 then 8'hFF; requester 1 is granted only after the DO_RENDER push.
- Command with magic 9 and then magic 8'hFF from a requester: both acknowledged, q_level unchanged, bad_cmd_cnt=2. 300 bad commands -> bad_cmd_cnt=255.
- Assert reset with 7 entries queued and commit pending: next cycle render_q_lw=1, q_level=0; no DO_RENDER emitted after reset is released.
